muldiv_ctrl: RTL and testbench

Sequencer for the shared multiply/divide unit of the multicycle processor. It accepts MULT/DIV requests from the main control unit and holds the operands on the unit's operand bus. It launches the booth multiplier or the divider with a one-cycle start pulse, tracks the unit's busy flag, captures results into architectural HI/LO registers and stalls the control FSM until the result is committed. It also detects divide-by-zero before launch and, optionally, aborts a hung unit with a watchdog.

---
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: operand bus, launch pulses, HI/LO capture, stall.
// Optional watchdog abort is compiled in with MULDIV_WDOG_EN.
module muldiv_ctrl
`ifdef MULDIV_WDOG_EN
#(
  parameter int unsigned WDOG_CYCLES = 64
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_req,
  input  logic        op_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        stall,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] unit_x,
  output logic [31:0] unit_y,
  output logic        mult_start,
  output logic        div_start,
  output logic        unit_rst,
  input  logic        mult_busy,
  input  logic        div_busy,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
`ifdef MULDIV_WDOG_EN
  localparam logic [2:0] ABORT     = 3'd5;
`endif

  logic [2:0] state_q, state_d;
  logic       op_sel_q;
  logic       dz_q, dz_d;
  logic       accept;
  logic       load;
  logic       sel_busy;
  logic       wdog_expired;

  assign sel_busy = op_sel_q ? div_busy : mult_busy;

`ifdef MULDIV_WDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);

  logic [CntW-1:0] wdog_q;

  // Counts cycles spent waiting on the unit; cleared on the way into WAIT_BUSY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog_q <= '0;
    end else if (state_q == LAUNCH) begin
      wdog_q <= '0;
    end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_expired = (wdog_q == CntW'(WDOG_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    dz_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_req) begin
          if (op_div && (op_b == '0)) begin
            // Divide-by-zero never reaches the unit; HI/LO keep their values.
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = LAUNCH;
            accept  = 1'b1;
          end
        end
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (sel_busy) begin
          state_d = WAIT_DONE;
`ifdef MULDIV_WDOG_EN
        end else if (wdog_expired) begin
          state_d = ABORT;
`endif
        end
      end
      WAIT_DONE: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (!sel_busy) begin
          state_d = DONE;
          load    = 1'b1;
`ifdef MULDIV_WDOG_EN
        end else if (wdog_expired) begin
          state_d = ABORT;
`endif
        end
      end
      DONE: state_d = IDLE;
`ifdef MULDIV_WDOG_EN
      ABORT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_sel_q <= 1'b0;
      dz_q     <= 1'b0;
      unit_x   <= '0;
      unit_y   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
      if (accept) begin
        unit_x   <= op_a;
        unit_y   <= op_b;
        op_sel_q <= op_div;
      end
      if (load) begin
        hi <= op_sel_q ? div_hi : mult_hi;
        lo <= op_sel_q ? div_lo : mult_lo;
      end
    end
  end

  assign mult_start   = (state_q == LAUNCH) && !op_sel_q;
  assign div_start    = (state_q == LAUNCH) && op_sel_q;
  assign div_zero_exc = dz_q;

`ifdef MULDIV_WDOG_EN
  assign done        = (state_q == DONE) || (state_q == ABORT);
  assign timeout_err = (state_q == ABORT);
  assign unit_rst    = !reset || (state_q == ABORT);
  assign stall       = !((state_q == IDLE) || (state_q == DONE) || (state_q == ABORT)) ||
                       ((state_q == IDLE) && op_req);
`else
  assign done        = (state_q == DONE);
  assign timeout_err = 1'b0;
  assign unit_rst    = !reset;
  assign stall       = !((state_q == IDLE) || (state_q == DONE)) ||
                       ((state_q == IDLE) && op_req);
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural mult/div unit stub.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        op_req;
  logic        op_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        done;
  logic        div_zero_exc;
  logic        timeout_err;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] unit_x;
  logic [31:0] unit_y;
  logic        mult_start;
  logic        div_start;
  logic        unit_rst;
  logic        mult_busy;
  logic        div_busy;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  muldiv_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op_req       (op_req),
    .op_div       (op_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .timeout_err  (timeout_err),
    .hi           (hi),
    .lo           (lo),
    .unit_x       (unit_x),
    .unit_y       (unit_y),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .unit_rst     (unit_rst),
    .mult_busy    (mult_busy),
    .div_busy     (div_busy),
    .mult_hi      (mult_hi),
    .mult_lo      (mult_lo),
    .div_hi       (div_hi),
    .div_lo       (div_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit stub: busy for busy_len cycles after a start; stuck freezes busy high.
  int          busy_len;
  logic        stuck;
  int          m_cnt;
  int          d_cnt;
  logic [31:0] stub_q;
  logic [31:0] stub_r;
  logic signed [63:0] prod;

  always @(posedge clk) begin
    if (unit_rst) begin
      m_cnt <= 0;
      d_cnt <= 0;
    end else begin
      if (mult_start) m_cnt <= busy_len;
      else if (m_cnt > 0 && !stuck) m_cnt <= m_cnt - 1;
      if (div_start) d_cnt <= busy_len;
      else if (d_cnt > 0 && !stuck) d_cnt <= d_cnt - 1;
    end
  end

  assign mult_busy = (m_cnt != 0);
  assign div_busy  = (d_cnt != 0);
  assign prod      = 64'($signed(unit_x)) * 64'($signed(unit_y));
  assign mult_hi   = prod[63:32];
  assign mult_lo   = prod[31:0];
  assign div_hi    = stub_r;
  assign div_lo    = stub_q;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-operation observations; cycle 0 is the request cycle, -1 means never seen.
  int          r_done_cyc;
  int          r_ms;
  int          r_ds;
  int          r_start_cyc;
  int          r_stall_low;
  logic        r_dz;
  logic        r_to;
  logic        r_urst;
  logic [31:0] r_ux;
  logic [31:0] r_uy;

  // Called at a negedge in IDLE; returns at the negedge of the done cycle.
  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                        input int max_cyc, input int toggle_at);
    op_req = 1'b1;
    op_div = div;
    op_a   = a;
    op_b   = b;
    r_done_cyc  = -1;
    r_ms        = 0;
    r_ds        = 0;
    r_start_cyc = -1;
    r_stall_low = -1;
    r_dz = 1'b0;
    r_to = 1'b0;
    r_urst = 1'b0;
    r_ux = '0;
    r_uy = '0;
    for (int c = 0; c <= max_cyc; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      if (c == toggle_at) op_req = 1'b0;
      if (c == toggle_at + 1) op_req = 1'b1;
      if (mult_start) r_ms++;
      if (div_start) r_ds++;
      if ((mult_start || div_start) && r_start_cyc < 0) r_start_cyc = c;
      if (c == 1) begin
        r_ux = unit_x;
        r_uy = unit_y;
      end
      if (!stall && r_stall_low < 0) r_stall_low = c;
      if (done) begin
        r_done_cyc = c;
        r_dz   = div_zero_exc;
        r_to   = timeout_err;
        r_urst = unit_rst;
        break;
      end
    end
    op_req = 1'b0;
  endtask

  int n_done;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    op_req   = 1'b0;
    op_div   = 1'b0;
    op_a     = '0;
    op_b     = '0;
    busy_len = 32;
    stuck    = 1'b0;
    stub_q   = 32'h0;
    stub_r   = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_unit_rst", 64'(unit_rst), 64'd1);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_start", 64'({mult_start, div_start}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("run_unit_rst", 64'(unit_rst), 64'd0);

    // MULT 7 * -3
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 60, -1);
    check_eq("mul_done_cyc", 64'(r_done_cyc), 64'd35);
    check_eq("mul_starts", 64'(r_ms), 64'd1);
    check_eq("mul_start_cyc", 64'(r_start_cyc), 64'd1);
    check_eq("mul_div_starts", 64'(r_ds), 64'd0);
    check_eq("mul_stall_low", 64'(r_stall_low), 64'd35);
    check_eq("mul_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("mul_lo", 64'(lo), 64'hFFFF_FFEB);
    check_eq("mul_flags", 64'({r_dz, r_to}), 64'd0);
    check_eq("mul_unit_xy", {r_ux, r_uy}, {32'd7, 32'hFFFF_FFFD});
    @(negedge clk);

    // DIV 100 / 7
    stub_q = 32'd14;
    stub_r = 32'd2;
    run_op(1'b1, 32'd100, 32'd7, 60, -1);
    check_eq("div_done_cyc", 64'(r_done_cyc), 64'd35);
    check_eq("div_starts", 64'(r_ds), 64'd1);
    check_eq("div_mul_starts", 64'(r_ms), 64'd0);
    check_eq("div_lo", 64'(lo), 64'd14);
    check_eq("div_hi", 64'(hi), 64'd2);
    @(negedge clk);

    // Preload HI/LO, then divide by zero
    stub_q = 32'h5555;
    stub_r = 32'hAAAA;
    run_op(1'b1, 32'd9, 32'd3, 60, -1);
    check_eq("pre_hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
    @(negedge clk);
    run_op(1'b1, 32'd5, 32'd0, 10, -1);
    check_eq("dz_done_cyc", 64'(r_done_cyc), 64'd1);
    check_eq("dz_exc", 64'(r_dz), 64'd1);
    check_eq("dz_starts", 64'(r_ms + r_ds), 64'd0);
    check_eq("dz_stall_low", 64'(r_stall_low), 64'd1);
    check_eq("dz_hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
    @(negedge clk);

    // op_req toggled mid-wait, then back-to-back request right after DONE
    run_op(1'b0, 32'h0001_2345, 32'h10, 60, 20);
    check_eq("tog_done_cyc", 64'(r_done_cyc), 64'd35);
    check_eq("tog_starts", 64'(r_ms), 64'd1);
    check_eq("tog_hilo", {hi, lo}, {32'h0, 32'h0012_3450});
    @(negedge clk);
    stub_q = 32'd22;
    stub_r = 32'd2;
    run_op(1'b1, 32'd200, 32'd9, 60, -1);
    check_eq("b2b_start_cyc", 64'(r_start_cyc), 64'd1);
    check_eq("b2b_done_cyc", 64'(r_done_cyc), 64'd35);
    check_eq("b2b_unit_x", 64'(r_ux), 64'd200);
    check_eq("b2b_lo", 64'(lo), 64'd22);
    @(negedge clk);

    // Reset in cycle 10 of a MULT
    op_req = 1'b1;
    op_div = 1'b0;
    op_a   = 32'd5;
    op_b   = 32'd6;
    #1;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mrst_unit_rst", 64'(unit_rst), 64'd1);
    @(negedge clk);
    reset  = 1'b1;
    op_req = 1'b0;
    #1;
    check_eq("mrst_hilo", {hi, lo}, 64'd0);
    check_eq("mrst_unit_xy", {unit_x, unit_y}, 64'd0);
    check_eq("mrst_stall", 64'(stall), 64'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("mrst_no_done", 64'(n_done), 64'd0);

`ifdef MULDIV_WDOG_EN
    // Unit hangs with busy high: watchdog abort, then a normal op
    stuck = 1'b1;
    run_op(1'b0, 32'd3, 32'd4, 80, -1);
    check_eq("wd_done_cyc", 64'(r_done_cyc), 64'd66);
    check_eq("wd_flags", 64'({r_to, r_urst}), 64'd3);
    check_eq("wd_hilo", {hi, lo}, 64'd0);
    stuck = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'd3, 32'd4, 60, -1);
    check_eq("wd_next_done", 64'(r_done_cyc), 64'd35);
    check_eq("wd_next_to", 64'(r_to), 64'd0);
    check_eq("wd_next_lo", 64'(lo), 64'd12);
`else
    check_eq("no_wdog_to", 64'(timeout_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
